// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// parameter defaults and a small handshake helper.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEF_PC_INC   = 4;

  // The IF/ID slot can take a new word if it is empty or being drained now.
  function automatic logic slot_is_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ack bus and IF/ID valid/ready bus of the fetch stage.
interface instr_fetch_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             ifid_valid;
  logic             ifid_ready;
  logic [WIDTH-1:0] ifid_instr;
  logic [WIDTH-1:0] ifid_npc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output ifid_valid, ifid_instr, ifid_npc,
    input  ifid_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  ifid_valid, ifid_instr, ifid_npc,
    output ifid_ready
  );
endinterface

// File: rtl/instr_fetch_ifid_latch.sv
// IF/ID pipeline latch: instruction word plus its PC+increment, with a valid
// flag that is loaded, held under backpressure, consumed or cleared.
module ifid_latch #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             ready,
  input  logic [WIDTH-1:0] load_instr,
  input  logic [WIDTH-1:0] load_npc,
  output logic             valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] npc
);
  logic             valid_reg;
  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] npc_reg;

  // Clear wins over load; the payload is left in place when invalidated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      npc_reg   <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= load_instr;
      npc_reg   <= load_npc;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign npc   = npc_reg;
endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, imem request sequencing and the
// REQ/HOLD/DRAIN control FSM feeding the IF/ID latch.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int unsigned      PC_INC   = DEF_PC_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] npc,
  input  logic             flush,
  instr_fetch_if.master    bus
);
  fetch_state_t     state_reg, state_next;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] hold_instr_reg;
  logic [WIDTH-1:0] hold_npc_reg;

  logic             slot_free;
  logic             latch_load;
  logic [WIDTH-1:0] latch_instr;
  logic [WIDTH-1:0] latch_npc;
  logic             hold_capture;
  logic             pc_load;
  logic             addr_load;
  logic [WIDTH-1:0] addr_val;

  assign npc           = pc_reg + WIDTH'(PC_INC);
  assign bus.imem_addr = addr_reg;
  assign slot_free     = slot_is_free(bus.ifid_valid, bus.ifid_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_REQ;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_REQ: begin
        if (flush && !bus.imem_ack)
          state_next = ST_DRAIN;
        else if (bus.imem_ack && !flush && !slot_free)
          state_next = ST_HOLD;
      end
      ST_HOLD:  if (flush || bus.ifid_ready) state_next = ST_REQ;
      ST_DRAIN: if (bus.imem_ack) state_next = ST_REQ;
      default:  state_next = ST_REQ;
    endcase
  end

  // In REQ and DRAIN, pc and imem_addr only diverge while a stale request drains.
  always_comb begin
    bus.imem_req = (state_reg != ST_HOLD);
    latch_load   = 1'b0;
    latch_instr  = hold_instr_reg;
    latch_npc    = hold_npc_reg;
    hold_capture = 1'b0;
    pc_load      = flush;
    addr_load    = 1'b0;
    addr_val     = pc_next;
    case (state_reg)
      ST_REQ: begin
        if (bus.imem_ack) begin
          pc_load   = 1'b1;
          addr_load = 1'b1;
          if (!flush) begin
            if (slot_free) begin
              latch_load  = 1'b1;
              latch_instr = bus.imem_rdata;
              latch_npc   = npc;
            end else begin
              hold_capture = 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (flush)               addr_load  = 1'b1;
        else if (bus.ifid_ready) latch_load = 1'b1;
      end
      ST_DRAIN: begin
        if (bus.imem_ack) begin
          addr_load = 1'b1;
          addr_val  = flush ? pc_next : pc_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      addr_reg       <= RESET_PC;
      hold_instr_reg <= '0;
      hold_npc_reg   <= '0;
    end else begin
      if (pc_load)   pc_reg   <= pc_next;
      if (addr_load) addr_reg <= addr_val;
      if (flush) begin
        hold_instr_reg <= '0;
        hold_npc_reg   <= '0;
      end else if (hold_capture) begin
        hold_instr_reg <= bus.imem_rdata;
        hold_npc_reg   <= npc;
      end
    end
  end

  ifid_latch #(.WIDTH(WIDTH)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (latch_load),
    .clear      (flush),
    .ready      (bus.ifid_ready),
    .load_instr (latch_instr),
    .load_npc   (latch_npc),
    .valid      (bus.ifid_valid),
    .instr      (bus.ifid_instr),
    .npc        (bus.ifid_npc)
  );
endmodule
